// File: rtl/multiword_add_seq.sv
// ----------------------------------------------------------------------------
// multiword_add_seq
//
// Adds two WIDTH*WORDS-bit operands one WIDTH-bit chunk at a time. The adder
// itself is an external n-bit CLA slice. This block sequences the chunks
// through it, least significant chunk first. Each chunk is given SETTLE clock
// cycles to settle. The carry between chunks passes through a register.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   a, b, c_in          wide operands and the initial carry-in
//   add_a, add_b        chunk operands driven to the external CLA
//   add_cin             chunk carry-in driven to the external CLA
//   add_sum, add_cout   chunk sum and carry-out returned by the external CLA
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   sum, c_out          wide result and final carry-out (held until the next
//                       capture overwrites them)
// ----------------------------------------------------------------------------
module multiword_add_seq #(
   parameter int WIDTH  = 16,
   parameter int WORDS  = 4,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   input  logic                   c_in,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_sum,
   input  logic                   add_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*WORDS-1:0] sum,
   output logic                   c_out
);

   localparam int TOTAL = WIDTH * WORDS;
   localparam int IW    = (WORDS  > 1) ? $clog2(WORDS)  : 1;
   localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   // The latched operands shift right by one chunk per capture. As a result,
   // the current chunk is always in the low WIDTH bits of these registers.
   logic [TOTAL-1:0]  a_sh;
   logic [TOTAL-1:0]  b_sh;
   logic              carry;
   logic [IW-1:0]     idx;
   logic [CW-1:0]     cnt;

   logic              capture;
   logic              last_chunk;

   assign capture    = (state == ADD) && (cnt == CW'(SETTLE - 1));
   assign last_chunk = (idx == IW'(WORDS - 1));

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: clocked processes use non-blocking assignments only. Every register
   // then samples the values from before the edge, whatever the process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: each combinational process assigns a default to every output
   // before any branch. This means no path can leave a value unassigned and
   // infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid)               state_next = ADD;
         ADD:     if (capture && last_chunk)  state_next = DONE;
         DONE:    if (out_ready)              state_next = IDLE;
         default:                             state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic (Moore): handshakes and CLA drive depend on state only.
   // add_cin comes from the carry register, so add_cout has no combinational
   // path to add_cin.
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      unique case (state)
         IDLE: in_ready  = 1'b1;
         ADD: begin
            add_a   = a_sh[WIDTH-1:0];
            add_b   = b_sh[WIDTH-1:0];
            add_cin = carry;
         end
         DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         cnt   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  idx   <= '0;
                  cnt   <= '0;
               end
            end
            ADD: begin
               if (capture) begin
                  sum[idx*WIDTH +: WIDTH] <= add_sum;
                  carry <= add_cout;
                  cnt   <= '0;
                  a_sh  <= a_sh >> WIDTH;
                  b_sh  <= b_sh >> WIDTH;
                  if (last_chunk) c_out <= add_cout;
                  else            idx   <= idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
